// File: rtl/iq_pkg.sv
// iq_pkg: shared types and sizes for the issue-queue ready tracker.
//
// Contents
//   ISSUE_DEPTH / ISSUE_DEPTH_LOG   number of IQ entries and index width
//   DISPATCH_WIDTH                  entries allocated per cycle
//   WAKEUP_WIDTH                    tag broadcasts per cycle
//   PHYS_TAG_W                      physical register tag width
//   phys_tag_t, iq_idx_t            tag and entry-index types
//   iq_entry_state_t                per-entry {valid, r1, r2} flop set
//   tagHit()                        does a tag match any valid broadcast this cycle
package iq_pkg;

  localparam int ISSUE_DEPTH     = 32;
  localparam int ISSUE_DEPTH_LOG = 5;
  localparam int DISPATCH_WIDTH  = 2;
  localparam int WAKEUP_WIDTH    = 4;
  localparam int PHYS_TAG_W      = 7;

  typedef logic [PHYS_TAG_W-1:0]      phys_tag_t;
  typedef logic [ISSUE_DEPTH_LOG-1:0] iq_idx_t;

  typedef struct packed {
    logic valid;
    logic r1;
    logic r2;
  } iq_entry_state_t;

  // One comparator per broadcast lane, OR-reduced. Shared by the CAM and
  // by the optional dispatch-time bypass so both see identical match rules.
  function automatic logic tagHit(
    input phys_tag_t                           tag,
    input logic [WAKEUP_WIDTH-1:0]             wakeValid,
    input logic [WAKEUP_WIDTH*PHYS_TAG_W-1:0]  wakeTags
  );
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < WAKEUP_WIDTH; w++) begin
      if (wakeValid[w] && (wakeTags[w*PHYS_TAG_W +: PHYS_TAG_W] == tag)) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/iq_wakeup_cam.sv
// iq_wakeup_cam: tag store for one issue-queue entry plus the wakeup
// comparators that produce the set-enables for its two ready bits.
//
// Ports
//   clk, reset      clock; asynchronous active-low reset
//   writeEn         load new source tags (dispatch into this entry)
//   writeSrc1Tag    source-1 tag to load
//   writeSrc2Tag    source-2 tag to load
//   wakeValid       per-lane broadcast strobe
//   wakeTag         packed broadcast tags, WAKEUP_WIDTH lanes
//   setR1, setR2    a valid broadcast matches the stored source tag
//
// The set-enables are raw matches; the owner decides whether the entry is
// valid and whether a higher-priority event overrides them.
module iq_wakeup_cam
  import iq_pkg::*;
(
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               writeEn,
  input  phys_tag_t                          writeSrc1Tag,
  input  phys_tag_t                          writeSrc2Tag,
  input  logic [WAKEUP_WIDTH-1:0]            wakeValid,
  input  logic [WAKEUP_WIDTH*PHYS_TAG_W-1:0] wakeTag,
  output logic                               setR1,
  output logic                               setR2
);

  phys_tag_t src1TagQ;
  phys_tag_t src2TagQ;

  // Tags are only rewritten on dispatch; they hold while the entry waits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src1TagQ <= '0;
      src2TagQ <= '0;
    end else if (writeEn) begin
      src1TagQ <= writeSrc1Tag;
      src2TagQ <= writeSrc2Tag;
    end
  end

  // Compare both stored tags against every broadcast lane.
  always_comb begin
    setR1 = tagHit(src1TagQ, wakeValid, wakeTag);
    setR2 = tagHit(src2TagQ, wakeValid, wakeTag);
  end

endmodule

// File: rtl/iq_ready_tracker.sv
// iq_ready_tracker: per-entry valid and source-ready state for the issue
// queue, feeding the select tree with a ready-to-issue request vector.
//
// Ports
//   clk              clock, all state on rising edge
//   reset            asynchronous active-low reset
//   flush_i          synchronous squash of every entry
//   dispValid_i      per-lane dispatch strobe
//   dispEntry_i      packed target entry per lane
//   dispSrc1Tag_i    packed source-1 tag per lane
//   dispSrc2Tag_i    packed source-2 tag per lane
//   dispSrc1Rdy_i    source-1 ready at dispatch, per lane
//   dispSrc2Rdy_i    source-2 ready at dispatch, per lane
//   wakeValid_i      wakeup broadcast strobe per lane
//   wakeTag_i        packed wakeup destination tags
//   grantValid_i     select grant valid
//   grantEntry_i     granted entry index
//   requestVector_o  valid & r1 & r2 per entry
//   freeVector_o     ~valid per entry
//   occupancy_o      number of valid entries (bypass build only, else 0)
//
// Build option
//   IQ_WAKEUP_BYPASS_EN  when defined, a dispatching source is also marked
//                        ready if its tag is being broadcast in the same
//                        cycle, and occupancy_o reports the valid count.
//
// Every output is decoded from registers only; there is no input-to-output
// path. Per-entry update priority: flush > dispatch > grant-clear > wakeup.
module iq_ready_tracker
  import iq_pkg::*;
(
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    flush_i,
  input  logic [DISPATCH_WIDTH-1:0]               dispValid_i,
  input  logic [DISPATCH_WIDTH*ISSUE_DEPTH_LOG-1:0] dispEntry_i,
  input  logic [DISPATCH_WIDTH*PHYS_TAG_W-1:0]    dispSrc1Tag_i,
  input  logic [DISPATCH_WIDTH*PHYS_TAG_W-1:0]    dispSrc2Tag_i,
  input  logic [DISPATCH_WIDTH-1:0]               dispSrc1Rdy_i,
  input  logic [DISPATCH_WIDTH-1:0]               dispSrc2Rdy_i,
  input  logic [WAKEUP_WIDTH-1:0]                 wakeValid_i,
  input  logic [WAKEUP_WIDTH*PHYS_TAG_W-1:0]      wakeTag_i,
  input  logic                                    grantValid_i,
  input  logic [ISSUE_DEPTH_LOG-1:0]              grantEntry_i,
  output logic [ISSUE_DEPTH-1:0]                  requestVector_o,
  output logic [ISSUE_DEPTH-1:0]                  freeVector_o,
  output logic [ISSUE_DEPTH_LOG:0]                occupancy_o
);

  iq_entry_state_t [ISSUE_DEPTH-1:0] stateQ;
  iq_entry_state_t [ISSUE_DEPTH-1:0] stateD;

  logic [ISSUE_DEPTH-1:0] validVec;
  logic [ISSUE_DEPTH-1:0] setR1;
  logic [ISSUE_DEPTH-1:0] setR2;
  logic [ISSUE_DEPTH-1:0] dispHit;
  logic [ISSUE_DEPTH-1:0] selR1;
  logic [ISSUE_DEPTH-1:0] selR2;
  logic [ISSUE_DEPTH-1:0] tagWriteEn;
  phys_tag_t              selT1 [ISSUE_DEPTH];
  phys_tag_t              selT2 [ISSUE_DEPTH];

  iq_idx_t                    laneEntry [DISPATCH_WIDTH];
  phys_tag_t                  laneT1    [DISPATCH_WIDTH];
  phys_tag_t                  laneT2    [DISPATCH_WIDTH];
  logic [DISPATCH_WIDTH-1:0]  laneR1;
  logic [DISPATCH_WIDTH-1:0]  laneR2;

  // Unpack the dispatch lanes and form each lane's initial ready bits.
  // With the bypass, a tag broadcast in the dispatch cycle would otherwise
  // be missed because the CAM only holds the tag from the next edge on.
  always_comb begin
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      laneEntry[k] = dispEntry_i[k*ISSUE_DEPTH_LOG +: ISSUE_DEPTH_LOG];
      laneT1[k]    = dispSrc1Tag_i[k*PHYS_TAG_W +: PHYS_TAG_W];
      laneT2[k]    = dispSrc2Tag_i[k*PHYS_TAG_W +: PHYS_TAG_W];
`ifdef IQ_WAKEUP_BYPASS_EN
      laneR1[k]    = dispSrc1Rdy_i[k] | tagHit(laneT1[k], wakeValid_i, wakeTag_i);
      laneR2[k]    = dispSrc2Rdy_i[k] | tagHit(laneT2[k], wakeValid_i, wakeTag_i);
`else
      laneR1[k]    = dispSrc1Rdy_i[k];
      laneR2[k]    = dispSrc2Rdy_i[k];
`endif
    end
  end

  // Route lanes to entries. Lanes are scanned upward so that when two lanes
  // target the same entry the higher lane's contents are the ones kept.
  always_comb begin
    for (int e = 0; e < ISSUE_DEPTH; e++) begin
      dispHit[e] = 1'b0;
      selR1[e]   = 1'b0;
      selR2[e]   = 1'b0;
      selT1[e]   = '0;
      selT2[e]   = '0;
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
        if (dispValid_i[k] && (laneEntry[k] == iq_idx_t'(e))) begin
          dispHit[e] = 1'b1;
          selR1[e]   = laneR1[k];
          selR2[e]   = laneR2[k];
          selT1[e]   = laneT1[k];
          selT2[e]   = laneT2[k];
        end
      end
    end
  end

  // Per-entry next state. Clearing valid on a grant to an entry that is
  // already invalid leaves it unchanged, so stray grants need no filter.
  always_comb begin
    for (int e = 0; e < ISSUE_DEPTH; e++) begin
      stateD[e]     = stateQ[e];
      tagWriteEn[e] = 1'b0;
      if (flush_i) begin
        stateD[e] = '0;
      end else if (dispHit[e]) begin
        stateD[e].valid = 1'b1;
        stateD[e].r1    = selR1[e];
        stateD[e].r2    = selR2[e];
        tagWriteEn[e]   = 1'b1;
      end else if (grantValid_i && (grantEntry_i == iq_idx_t'(e))) begin
        stateD[e].valid = 1'b0;
      end else if (stateQ[e].valid) begin
        stateD[e].r1 = stateQ[e].r1 | setR1[e];
        stateD[e].r2 = stateQ[e].r2 | setR2[e];
      end
    end
  end

  // Entry state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ <= '0;
    end else begin
      stateQ <= stateD;
    end
  end

  // One tag CAM per entry.
  for (genvar e = 0; e < ISSUE_DEPTH; e++) begin : gEntryCam
    iq_wakeup_cam uCam (
      .clk          (clk),
      .reset        (reset),
      .writeEn      (tagWriteEn[e]),
      .writeSrc1Tag (selT1[e]),
      .writeSrc2Tag (selT2[e]),
      .wakeValid    (wakeValid_i),
      .wakeTag      (wakeTag_i),
      .setR1        (setR1[e]),
      .setR2        (setR2[e])
    );
  end

  // Register-only decode of the select-tree and free-list views.
  always_comb begin
    for (int e = 0; e < ISSUE_DEPTH; e++) begin
      validVec[e]        = stateQ[e].valid;
      requestVector_o[e] = stateQ[e].valid & stateQ[e].r1 & stateQ[e].r2;
    end
    freeVector_o = ~validVec;
  end

`ifdef IQ_WAKEUP_BYPASS_EN
  logic [ISSUE_DEPTH_LOG:0] occCount;

  // Population count of the valid bits.
  always_comb begin
    occCount = '0;
    for (int e = 0; e < ISSUE_DEPTH; e++) begin
      occCount = occCount + {{ISSUE_DEPTH_LOG{1'b0}}, validVec[e]};
    end
  end

  assign occupancy_o = occCount;
`else
  assign occupancy_o = '0;
`endif

  // Dispatch into a live entry means the free list upstream is corrupt.
  // A flush drops the dispatch, so that case is not an overwrite.
  for (genvar k = 0; k < DISPATCH_WIDTH; k++) begin : gOverwriteCheck
    assert property (@(posedge clk) disable iff (!reset)
      (dispValid_i[k] && !flush_i) |->
        !validVec[dispEntry_i[k*ISSUE_DEPTH_LOG +: ISSUE_DEPTH_LOG]]);
  end

endmodule

// File: tb/tb_iq_ready_tracker.sv
// tb_iq_ready_tracker: directed scenarios plus randomized traffic for
// iq_ready_tracker, checked against an entry-array reference model.
//
// Honours IQ_WAKEUP_BYPASS_EN the same way the design does.
module tb_iq_ready_tracker;
  import iq_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush;
  logic [1:0]  dispValid;
  logic [9:0]  dispEntry;
  logic [13:0] dispSrc1Tag;
  logic [13:0] dispSrc2Tag;
  logic [1:0]  dispSrc1Rdy;
  logic [1:0]  dispSrc2Rdy;
  logic [3:0]  wakeValid;
  logic [27:0] wakeTag;
  logic        grantValid;
  logic [4:0]  grantEntry;
  logic [31:0] reqVec;
  logic [31:0] freeVec;
  logic [5:0]  occ;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model: one record per entry.
  bit         mValid [32];
  bit         mR1    [32];
  bit         mR2    [32];
  logic [6:0] mT1    [32];
  logic [6:0] mT2    [32];

  always #5 clk = ~clk;

  iq_ready_tracker dut (
    .clk             (clk),
    .reset           (reset),
    .flush_i         (flush),
    .dispValid_i     (dispValid),
    .dispEntry_i     (dispEntry),
    .dispSrc1Tag_i   (dispSrc1Tag),
    .dispSrc2Tag_i   (dispSrc2Tag),
    .dispSrc1Rdy_i   (dispSrc1Rdy),
    .dispSrc2Rdy_i   (dispSrc2Rdy),
    .wakeValid_i     (wakeValid),
    .wakeTag_i       (wakeTag),
    .grantValid_i    (grantValid),
    .grantEntry_i    (grantEntry),
    .requestVector_o (reqVec),
    .freeVector_o    (freeVec),
    .occupancy_o     (occ)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic bit wakeHit(input logic [6:0] t);
    bit hit = 0;
    for (int w = 0; w < 4; w++)
      if (wakeValid[w] && wakeTag[w*7 +: 7] == t) hit = 1;
    return hit;
  endfunction

  task automatic modelReset();
    for (int e = 0; e < 32; e++) begin
      mValid[e] = 0; mR1[e] = 0; mR2[e] = 0; mT1[e] = '0; mT2[e] = '0;
    end
  endtask

  // Apply the rules in order of increasing priority on a copy of the old
  // state, so later rules simply overwrite earlier ones.
  task automatic modelStep();
    bit nV [32];
    bit n1 [32];
    bit n2 [32];
    nV = mValid; n1 = mR1; n2 = mR2;
    if (flush) begin
      for (int e = 0; e < 32; e++) nV[e] = 0;
    end else begin
      for (int e = 0; e < 32; e++) begin
        if (mValid[e] && wakeHit(mT1[e])) n1[e] = 1;
        if (mValid[e] && wakeHit(mT2[e])) n2[e] = 1;
      end
      if (grantValid) nV[grantEntry] = 0;
      for (int k = 0; k < 2; k++) begin
        if (dispValid[k]) begin
          int e = int'(dispEntry[k*5 +: 5]);
          nV[e]  = 1;
          mT1[e] = dispSrc1Tag[k*7 +: 7];
          mT2[e] = dispSrc2Tag[k*7 +: 7];
          n1[e]  = dispSrc1Rdy[k];
          n2[e]  = dispSrc2Rdy[k];
`ifdef IQ_WAKEUP_BYPASS_EN
          if (wakeHit(mT1[e])) n1[e] = 1;
          if (wakeHit(mT2[e])) n2[e] = 1;
`endif
        end
      end
    end
    mValid = nV; mR1 = n1; mR2 = n2;
  endtask

  task automatic checkAll(input string tag);
    logic [31:0] expReq = '0;
    logic [31:0] expFree = '0;
    int cnt = 0;
    for (int e = 0; e < 32; e++) begin
      expReq[e]  = mValid[e] & mR1[e] & mR2[e];
      expFree[e] = ~mValid[e];
      cnt += int'(mValid[e]);
    end
`ifndef IQ_WAKEUP_BYPASS_EN
    cnt = 0;
`endif
    checkOutput({tag, "_req"}, 64'(reqVec), 64'(expReq));
    checkOutput({tag, "_free"}, 64'(freeVec), 64'(expFree));
    checkOutput({tag, "_occ"}, 64'(occ), 64'(cnt));
  endtask

  task automatic clearInputs();
    flush = 0; dispValid = '0; dispEntry = '0; dispSrc1Tag = '0; dispSrc2Tag = '0;
    dispSrc1Rdy = '0; dispSrc2Rdy = '0; wakeValid = '0; wakeTag = '0;
    grantValid = 0; grantEntry = '0;
  endtask

  task automatic dispatchLane(input int k, input int e, input logic [6:0] t1, input logic [6:0] t2,
                              input logic r1, input logic r2);
    dispValid[k]        = 1'b1;
    dispEntry[k*5 +: 5] = 5'(e);
    dispSrc1Tag[k*7 +: 7] = t1;
    dispSrc2Tag[k*7 +: 7] = t2;
    dispSrc1Rdy[k] = r1;
    dispSrc2Rdy[k] = r2;
  endtask

  // Called at a falling edge with inputs driven; returns at the next one.
  task automatic tick(input string tag);
    modelStep();
    @(posedge clk);
    #1;
    checkAll(tag);
    @(negedge clk);
  endtask

  task automatic applyStimulus();
    int used = -1;
    clearInputs();
    flush = ($urandom_range(0, 49) == 0);
    for (int k = 0; k < 2; k++) begin
      if ($urandom_range(0, 9) < 6) begin
        int e = 0;
        bit found = 0;
        if (k == 1 && used >= 0 && $urandom_range(0, 7) == 0) begin
          e = used; found = 1;
        end else begin
          for (int t = 0; t < 8 && !found; t++) begin
            e = int'($urandom_range(0, 31));
            if (!mValid[e] && e != used) found = 1;
          end
        end
        if (found) begin
          dispatchLane(k, e, 7'($urandom_range(0, 15)), 7'($urandom_range(0, 15)),
                       ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3));
          used = e;
        end
      end
    end
    for (int w = 0; w < 4; w++) begin
      wakeValid[w]     = $urandom_range(0, 1) == 1;
      wakeTag[w*7 +: 7] = 7'($urandom_range(0, 15));
    end
    if ($urandom_range(0, 9) < 6) begin
      grantValid = 1;
      grantEntry = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) begin
        for (int t = 0; t < 8; t++) begin
          int g = int'($urandom_range(0, 31));
          if (mValid[g] && mR1[g] && mR2[g]) begin
            grantEntry = 5'(g);
            break;
          end
        end
      end
    end
  endtask

  initial begin
    clearInputs();
    modelReset();
    repeat (2) @(negedge clk);
    checkAll("reset");
    reset = 1;
    @(negedge clk);
    checkAll("release");

    // Ready-at-dispatch entry requests next cycle; grant removes it.
    dispatchLane(0, 3, 7'h01, 7'h02, 1, 1);
    tick("t1d");
    checkOutput("t1_req3", 64'(reqVec[3]), 64'd1);
    clearInputs(); grantValid = 1; grantEntry = 5'd3;
    tick("t1g");
    checkOutput("t1_gnt3", 64'(reqVec[3]), 64'd0);

    // Wakeup of a waiting source.
    clearInputs();
    dispatchLane(0, 5, 7'h12, 7'h01, 0, 1);
    tick("t2d");
    checkOutput("t2_early0", 64'(reqVec[5]), 64'd0);
    clearInputs();
    tick("t2i");
    checkOutput("t2_early1", 64'(reqVec[5]), 64'd0);
    wakeValid[2] = 1; wakeTag[14 +: 7] = 7'h12;
    tick("t2w");
    checkOutput("t2_woken", 64'(reqVec[5]), 64'd1);

    // Dispatch beats same-cycle grant to the same entry.
    clearInputs();
    dispatchLane(0, 7, 7'h03, 7'h04, 1, 1);
    grantValid = 1; grantEntry = 5'd7;
    tick("t3");
    checkOutput("t3_req7", 64'(reqVec[7]), 64'd1);

    // Fill every entry, then flush alongside a dispatch.
    for (int e = 0; e < 32; e++) begin
      if (!mValid[e]) begin
        clearInputs();
        dispatchLane(e % 2, e, 7'(e), 7'(e + 1), e[0], 1);
        tick("t4f");
      end
    end
    checkOutput("t4_full", 64'(freeVec), 64'd0);
    clearInputs();
    flush = 1;
    dispatchLane(1, 3, 7'h05, 7'h06, 1, 1);
    wakeValid[0] = 1; wakeTag[6:0] = 7'h05;
    tick("t4x");
    checkOutput("t4_req", 64'(reqVec), 64'd0);
    checkOutput("t4_free", 64'(freeVec), 64'hFFFF_FFFF);

    // Dispatch racing a broadcast of its own tag.
    clearInputs();
    dispatchLane(0, 9, 7'h20, 7'h05, 0, 1);
    wakeValid[0] = 1; wakeTag[6:0] = 7'h20;
    tick("t5");
`ifdef IQ_WAKEUP_BYPASS_EN
    checkOutput("t5_bypass", 64'(reqVec[9]), 64'd1);
`else
    checkOutput("t5_nobypass", 64'(reqVec[9]), 64'd0);
`endif
    clearInputs();
    tick("t5h");

    // Reset mid-burst with ten more entries live.
    for (int e = 10; e < 20; e += 2) begin
      clearInputs();
      dispatchLane(0, e, 7'h08, 7'h09, 1, 1);
      dispatchLane(1, e + 1, 7'h0A, 7'h0B, 1, 0);
      tick("t6f");
    end
    clearInputs();
    dispatchLane(0, 20, 7'h0C, 7'h0D, 1, 1);
    wakeValid[1] = 1; wakeTag[7 +: 7] = 7'h0B;
    #2 reset = 0;
    #1;
    modelReset();
    checkAll("t6_async");
    @(posedge clk); #1;
    checkAll("t6_held");
    @(negedge clk);
    reset = 1;
    clearInputs();
    dispatchLane(0, 4, 7'h11, 7'h22, 1, 1);
    tick("t6r");
    checkOutput("t6_req4", 64'(reqVec[4]), 64'd1);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      applyStimulus();
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #2000000;
    failCount++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
